// File: rtl/wash_indicator_ctrl.sv
// Washer panel light/buzzer controller: phase lights (steady/blink/off), start light,
// and a buzzer that plays key beeps and a grouped end-of-program melody.
module wash_indicator_ctrl #(
    parameter int NUM_PHASES      = 3,
    parameter int KEY_COUNT       = 4,
    parameter int BEEP_TICKS      = 25_000_000,
    parameter int GAP_TICKS       = 50_000_000,
    parameter int BEEPS_PER_GROUP = 3,
    parameter int END_GROUPS      = 3,
    parameter int BLINK_HALF      = 50_000_000,
    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  power_on,
    input  logic [KEY_COUNT-1:0]  keys,
    input  logic [NUM_PHASES-1:0] phase_mask,
    input  logic [PW-1:0]         cur_phase,
    input  logic [1:0]            run_state,
    input  logic                  finish,
    output logic [NUM_PHASES-1:0] phase_light,
    output logic                  start_light,
    output logic                  buzzer,
    output logic                  end_done
);

    localparam int MAX_BG = (BEEP_TICKS > GAP_TICKS) ? BEEP_TICKS : GAP_TICKS;
    localparam int MAX_T  = (MAX_BG > BLINK_HALF) ? MAX_BG : BLINK_HALF;
    localparam int TW     = $clog2(MAX_T + 1);
    localparam int BW     = $clog2(BEEPS_PER_GROUP + 1);
    localparam int GW     = $clog2(END_GROUPS + 1);

    localparam logic [TW-1:0] BEEP_LAST  = TW'(BEEP_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] BEEP_IDX_LAST = BW'(BEEPS_PER_GROUP - 1);
    localparam logic [GW-1:0] GRP_IDX_LAST  = GW'(END_GROUPS - 1);
    localparam logic [PW:0]   NP_W = (PW + 1)'(NUM_PHASES);

    typedef enum logic [2:0] {IDLE, KEY_BEEP, END_ON, END_OFF, END_GAP, DONE} state_t;

    state_t                  state;
    logic [TW-1:0]           timer;
    logic [BW-1:0]           beep_cnt;
    logic [GW-1:0]           grp_cnt;
    logic [TW-1:0]           blink_cnt;
    logic                    blink;
    logic [KEY_COUNT-1:0]    key_q;
    logic [NUM_PHASES-1:0]   pl_nxt;

    wire clear   = !reset || !power_on;
    wire key_hit = |(keys & ~key_q);
    wire running = (run_state == 2'b01);
    wire paused  = (run_state == 2'b10);
    wire cur_oor = ({1'b0, cur_phase} >= NP_W);

    // Per-phase light: done phases dark, active phase blinks, pending phases follow the mask.
    for (genvar i = 0; i < NUM_PHASES; i++) begin : g_phase
        localparam logic [PW-1:0] IDX = PW'(i);
        assign pl_nxt[i] = finish  ? 1'b1 :
                           running ? (cur_oor             ? phase_mask[i] :
                                      (IDX < cur_phase)   ? 1'b0 :
                                      (IDX == cur_phase)  ? blink : phase_mask[i]) :
                           paused  ? (phase_mask[i] | (IDX == cur_phase)) :
                                     phase_mask[i];
    end

    always_ff @(posedge clk) begin
        key_q <= keys;
        if (clear) begin
            blink_cnt   <= '0;
            blink       <= 1'b0;
            phase_light <= '0;
            start_light <= 1'b0;
        end else begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            phase_light <= pl_nxt;
            start_light <= running && !end_done;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            timer    <= '0;
            beep_cnt <= '0;
            grp_cnt  <= '0;
            buzzer   <= 1'b0;
            end_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (key_hit) begin
                        state  <= KEY_BEEP;
                        buzzer <= 1'b1;
                    end else if (finish && !end_done) begin
                        state  <= END_ON;
                        buzzer <= 1'b1;
                    end
                end
                KEY_BEEP: begin
                    if (timer == BEEP_LAST) begin
                        timer  <= '0;
                        state  <= finish ? END_ON : IDLE;
                        buzzer <= finish;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                END_ON, END_OFF, END_GAP: begin
                    // Program un-finished mid-melody: abandon it and forget progress.
                    if (!finish) begin
                        state    <= IDLE;
                        buzzer   <= 1'b0;
                        timer    <= '0;
                        beep_cnt <= '0;
                        grp_cnt  <= '0;
                    end else if (state == END_ON) begin
                        if (timer == BEEP_LAST) begin
                            timer  <= '0;
                            buzzer <= 1'b0;
                            if (beep_cnt != BEEP_IDX_LAST) begin
                                beep_cnt <= beep_cnt + 1'b1;
                                state    <= END_OFF;
                            end else if (grp_cnt != GRP_IDX_LAST) begin
                                beep_cnt <= '0;
                                grp_cnt  <= grp_cnt + 1'b1;
                                state    <= END_GAP;
                            end else begin
                                beep_cnt <= '0;
                                grp_cnt  <= '0;
                                end_done <= 1'b1;
                                state    <= DONE;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end else if (timer == ((state == END_GAP) ? GAP_LAST : BEEP_LAST)) begin
                        timer  <= '0;
                        buzzer <= 1'b1;
                        state  <= END_ON;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    buzzer <= 1'b0;
                    if (!finish) begin
                        end_done <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    buzzer <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_indicator_ctrl.sv
// Randomized and directed bench for wash_indicator_ctrl; the melody and light
// expectations are computed from timeline arithmetic, not from a state machine.
module tb_wash_indicator_ctrl;

    localparam int NP  = 3;
    localparam int KC  = 4;
    localparam int BT  = 4;
    localparam int GAP = 8;
    localparam int BPG = 3;
    localparam int EG  = 3;
    localparam int BH  = 2;
    localparam int GRP_LEN = (2 * BPG - 1) * BT + GAP;
    localparam int MEL_LEN = EG * GRP_LEN - GAP;

    logic          clk = 1'b0;
    logic          reset;
    logic          power_on;
    logic [KC-1:0] keys;
    logic [NP-1:0] phase_mask;
    logic [1:0]    cur_phase;
    logic [1:0]    run_state;
    logic          finish;
    logic [NP-1:0] phase_light;
    logic          start_light;
    logic          buzzer;
    logic          end_done;

    int errors = 0;
    int checks = 0;
    int n = 0;

    wash_indicator_ctrl #(
        .NUM_PHASES(NP), .KEY_COUNT(KC), .BEEP_TICKS(BT), .GAP_TICKS(GAP),
        .BEEPS_PER_GROUP(BPG), .END_GROUPS(EG), .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .reset(reset), .power_on(power_on), .keys(keys),
        .phase_mask(phase_mask), .cur_phase(cur_phase), .run_state(run_state),
        .finish(finish), .phase_light(phase_light), .start_light(start_light),
        .buzzer(buzzer), .end_done(end_done)
    );

    always #5 clk = ~clk;

    // n = edges since the last clearing edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!reset || !power_on) n = 0;
        else n++;
        #1;
    endtask

    function automatic logic mel_buz(input int t);
        int r;
        if (t >= MEL_LEN) return 1'b0;
        r = t % GRP_LEN;
        return (r < (2 * BPG - 1) * BT) && (((r / BT) % 2) == 0);
    endfunction

    function automatic logic [NP-1:0] exp_pl(input logic [NP-1:0] m, input logic [1:0] c,
                                             input logic [1:0] r, input logic f, input int nn);
        logic [NP-1:0] e;
        logic b;
        int ci;
        ci = c;
        b = (((nn - 1) / BH) % 2) == 1;
        e = m;
        if (f) e = '1;
        else if (r == 2'b01) begin
            if (ci < NP)
                for (int i = 0; i < NP; i++)
                    e[i] = (i < ci) ? 1'b0 : (i == ci) ? b : m[i];
        end else if (r == 2'b10) begin
            if (ci < NP) e[ci] = 1'b1;
        end
        return e;
    endfunction

    task automatic test_reset();
        reset = 0; power_on = 1; keys = 4'b0010; phase_mask = 3'b101;
        cur_phase = 0; run_state = 2'b01; finish = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({phase_light, start_light, buzzer, end_done} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b expected 000000",
                         {phase_light, start_light, buzzer, end_done});
            end
        end
        reset = 1; run_state = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (buzzer !== 1'b0 || phase_light !== 3'b101) begin
                errors++;
                $display("FAIL reset_release: buzzer=%b lights=%b expected 0 101", buzzer, phase_light);
            end
        end
    endtask

    task automatic test_key_single();
        logic exp_b;
        keys = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) keys = 4'b0111;
            exp_b = (i < BT);
            checks++;
            if (buzzer !== exp_b) begin
                errors++;
                $display("FAIL key_beep[%0d]: buzzer=%b expected %b", i, buzzer, exp_b);
            end
        end
        keys = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_key_random();
        int busy_end = -1;
        logic [KC-1:0] kprev;
        logic exp_b;
        kprev = keys;
        for (int c = 0; c < 120; c++) begin
            if ($urandom_range(0, 3) == 0) keys = 4'($urandom_range(0, 15));
            tick();
            if (|(keys & ~kprev) && c > busy_end) busy_end = c + BT;
            kprev = keys;
            exp_b = (c < busy_end);
            checks++;
            if (buzzer !== exp_b) begin
                errors++;
                $display("FAIL key_random[%0d]: buzzer=%b expected %b keys=%b", c, buzzer, exp_b, keys);
            end
        end
        keys = 4'b0000;
        for (int i = 0; i < BT + 2; i++) tick();
    endtask

    task automatic test_phase_lights();
        logic [NP-1:0] e;
        run_state = 2'b01; phase_mask = 3'b111; cur_phase = 2'd1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = exp_pl(phase_mask, cur_phase, run_state, finish, n);
            checks++;
            if (phase_light !== e || start_light !== 1'b1) begin
                errors++;
                $display("FAIL run_lights[%0d]: lights=%b start=%b expected %b 1", i, phase_light, start_light, e);
            end
        end
        run_state = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (phase_light !== 3'b111 || start_light !== 1'b0) begin
                errors++;
                $display("FAIL pause_lights[%0d]: lights=%b start=%b expected 111 0", i, phase_light, start_light);
            end
        end
    endtask

    task automatic test_phase_random();
        logic [NP-1:0] e;
        for (int i = 0; i < 80; i++) begin
            phase_mask = 3'($urandom_range(0, 7));
            cur_phase  = 2'($urandom_range(0, 3));
            run_state  = 2'($urandom_range(0, 3));
            tick();
            e = exp_pl(phase_mask, cur_phase, run_state, finish, n);
            checks++;
            if (phase_light !== e || start_light !== (run_state == 2'b01)) begin
                errors++;
                $display("FAIL phase_random[%0d]: lights=%b start=%b expected %b %b (m=%b c=%0d r=%b)",
                         i, phase_light, start_light, e, run_state == 2'b01, phase_mask, cur_phase, run_state);
            end
        end
        run_state = 2'b01; phase_mask = 3'b010; cur_phase = 2'd1;
        tick();
    endtask

    task automatic test_melody();
        logic eb, ed, es;
        finish = 1;
        for (int t = 0; t < MEL_LEN + 4; t++) begin
            tick();
            if (t == 5) keys = 4'b1000;
            eb = mel_buz(t);
            ed = (t >= MEL_LEN);
            es = (t <= MEL_LEN);
            checks++;
            if (buzzer !== eb || end_done !== ed || start_light !== es || phase_light !== 3'b111) begin
                errors++;
                $display("FAIL melody[%0d]: buz=%b done=%b start=%b lights=%b expected %b %b %b 111",
                         t, buzzer, end_done, start_light, phase_light, eb, ed, es);
            end
        end
        finish = 0;
        tick();
        checks++;
        if (end_done !== 1'b0 || buzzer !== 1'b0) begin
            errors++;
            $display("FAIL melody_release: done=%b buz=%b expected 0 0", end_done, buzzer);
        end
        keys = 4'b0000;
        tick();
    endtask

    task automatic test_abort();
        logic eb;
        finish = 1;
        for (int t = 0; t < 10; t++) begin
            tick();
            checks++;
            if (buzzer !== mel_buz(t)) begin
                errors++;
                $display("FAIL abort_pre[%0d]: buz=%b expected %b", t, buzzer, mel_buz(t));
            end
        end
        finish = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (buzzer !== 1'b0 || end_done !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet[%0d]: buz=%b done=%b expected 0 0", i, buzzer, end_done);
            end
        end
        keys = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            eb = (i < BT);
            checks++;
            if (buzzer !== eb) begin
                errors++;
                $display("FAIL abort_key[%0d]: buz=%b expected %b", i, buzzer, eb);
            end
        end
        keys = 4'b0000;
        tick();
        finish = 1;
        for (int t = 0; t < 30; t++) begin
            tick();
            checks++;
            if (buzzer !== mel_buz(t)) begin
                errors++;
                $display("FAIL abort_restart[%0d]: buz=%b expected %b", t, buzzer, mel_buz(t));
            end
        end
        finish = 0;
        tick(); tick();
    endtask

    task automatic test_power();
        logic ed;
        finish = 1;
        for (int t = 0; t < 21; t++) begin
            tick();
            checks++;
            if (buzzer !== mel_buz(t)) begin
                errors++;
                $display("FAIL power_pre[%0d]: buz=%b expected %b", t, buzzer, mel_buz(t));
            end
        end
        power_on = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({phase_light, start_light, buzzer, end_done} !== 6'b0) begin
                errors++;
                $display("FAIL power_off[%0d]: got %b expected 000000", i,
                         {phase_light, start_light, buzzer, end_done});
            end
        end
        power_on = 1;
        for (int t = 0; t < MEL_LEN + 2; t++) begin
            tick();
            ed = (t >= MEL_LEN);
            checks++;
            if (buzzer !== mel_buz(t) || end_done !== ed) begin
                errors++;
                $display("FAIL power_restart[%0d]: buz=%b done=%b expected %b %b",
                         t, buzzer, end_done, mel_buz(t), ed);
            end
        end
        finish = 0;
        tick();
        checks++;
        if (end_done !== 1'b0) begin
            errors++;
            $display("FAIL power_release: done=%b expected 0", end_done);
        end
    endtask

    initial begin
        test_reset();
        test_key_single();
        test_key_random();
        test_phase_lights();
        test_phase_random();
        test_melody();
        test_abort();
        test_power();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
